// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the two-port memory arbiter.
// ADDR_W/DATA_W match the defaults of the shared single-port memory block.
package mem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACC     = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ACC     = ST_ACC,
        RD_WAIT = ST_RD_WAIT
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and memory-side strobes.
// slave  : the arbiter (consumes requests, drives memory command).
// master : the surroundings (two requesters plus the memory block).
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          req0;
    logic          req1;
    logic          wr0;
    logic          wr1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          busy;
    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_dout,
        output ack0, ack1, rdata0, rdata1, busy,
               mem_cen, mem_wen, mem_addr, mem_din
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  ack0, ack1, rdata0, rdata1, busy,
               mem_cen, mem_wen, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker. `last` is the index of the
// requester granted most recently; on a tie the other one wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 & (~req1 | last);
    assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared single-port memory.
// One transaction at a time: write takes 2 cycles, read takes 3.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access in flight; arbitrate and latch the winner's command
// ACC     | memory strobe is high this cycle; writes finish here
// RD_WAIT | memory read data is valid; capture it for the owner
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    mem_arbiter_if.slave   bus
);

    state_t              r_state;
    state_t              w_next;
    logic                w_load;
    logic                w_ack_set;
    logic                w_rd_cap;
    logic                w_gnt0;
    logic                w_gnt1;

    logic                r_cen;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic                r_owner;
    logic                r_last;
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    rr_arb2 u_rr_arb2 (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (r_last),
        .gnt0 (w_gnt0),
        .gnt1 (w_gnt1)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control strobes. ACC looks at the latched
    // write flag, not the live request, since the requester may change it.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_ack_set = 1'b0;
        w_rd_cap  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt0 || w_gnt1) begin
                    w_load = 1'b1;
                    w_next = ACC;
                end
            end
            ACC: begin
                if (r_wen) begin
                    w_ack_set = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_rd_cap  = 1'b1;
                w_ack_set = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Memory command register: strobes last exactly one cycle, address and
    // write data hold their last values between transactions.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cen  <= 1'b0;
            r_wen  <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (w_load) begin
            r_cen  <= 1'b1;
            r_wen  <= w_gnt1 ? bus.wr1    : bus.wr0;
            r_addr <= w_gnt1 ? bus.addr1  : bus.addr0;
            r_din  <= w_gnt1 ? bus.wdata1 : bus.wdata0;
        end else begin
            r_cen  <= 1'b0;
            r_wen  <= 1'b0;
        end
    end

    // Owner of the transaction in flight and the round-robin history.
    // last starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_load) begin
            r_owner <= w_gnt1;
            r_last  <= w_gnt1;
        end
    end

    // One-cycle acknowledge to the owner, visible while the FSM is in IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
        end else begin
            r_ack0 <= w_ack_set & ~r_owner;
            r_ack1 <= w_ack_set &  r_owner;
        end
    end

    // Read data capture; each requester's data holds until its next read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_rd_cap) begin
            if (r_owner) begin
                r_rdata1 <= bus.mem_dout;
            end else begin
                r_rdata0 <= bus.mem_dout;
            end
        end
    end

    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
    assign bus.busy     = (r_state != IDLE);
    assign bus.mem_cen  = r_cen;
    assign bus.mem_wen  = r_wen;
    assign bus.mem_addr = r_addr;
    assign bus.mem_din  = r_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   viol;
    logic prev_cen;

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_dout;

    mem_arbiter_if bus ();

    mem_arbiter u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    assign bus.mem_dout = r_dout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read data, valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_cen === 1'b1) begin
            if (bus.mem_wen === 1'b1) r_mem[bus.mem_addr] <= bus.mem_din;
            else                      r_dout <= r_mem[bus.mem_addr];
        end
    end

    // Protocol monitor: no back-to-back strobes, never two acks at once.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.mem_cen === 1'b1 && prev_cen === 1'b1) viol++;
            if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1)    viol++;
        end
        prev_cen = bus.mem_cen;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic wr,
                         input logic [4:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0 = rq; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = rq; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // Single transaction from one requester; lat counts falling edges from
    // raising req to seeing ack (2 for a write, 3 for a read).
    task automatic run_txn(input int p, input logic wr, input logic [4:0] a,
                           input logic [31:0] d, output int lat, output logic [31:0] rd);
        logic ack;
        drive(p, 1'b1, wr, a, d);
        lat = 0;
        rd  = '0;
        ack = 1'b0;
        while (!ack && lat < 20) begin
            @(negedge clk);
            lat++;
            ack = (p == 0) ? bus.ack0 : bus.ack1;
        end
        rd = (p == 0) ? bus.rdata0 : bus.rdata1;
        drive(p, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        int          n;
        int          first_t;
        int          nack;
        logic [3:0]  ord;
        logic        done0, done1, ph0, ph1;
        logic [31:0] rd0, rd1;
        int          last_t;
        int          unstable;
        int          ack1_t;
        int          first_p;

        checks   = 0;
        errors   = 0;
        viol     = 0;
        prev_cen = 1'b0;
        r_dout   = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) r_mem[i] = '0;

        // Reset held 2 cycles with both requesters asking (writes 1->a1, 2->a2).
        reset_n = 1'b0;
        drive(0, 1'b1, 1'b1, 5'd1, 32'd1);
        drive(1, 1'b1, 1'b1, 5'd2, 32'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack0",     32'(bus.ack0),     32'd0);
        check("rst_ack1",     32'(bus.ack1),     32'd0);
        check("rst_rdata0",   bus.rdata0,        32'd0);
        check("rst_rdata1",   bus.rdata1,        32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_cen",      32'(bus.mem_cen),  32'd0);
        check("rst_wen",      32'(bus.mem_wen),  32'd0);
        check("rst_addr",     32'(bus.mem_addr), 32'd0);
        check("rst_din",      bus.mem_din,       32'd0);

        // Contention straight out of reset: writes then reads from both.
        reset_n = 1'b1;
        done0 = 1'b0; done1 = 1'b0; ph0 = 1'b0; ph1 = 1'b0;
        rd0 = '0; rd1 = '0; n = 0; nack = 0; ord = '0; first_t = 0; first_p = 9;
        while (!(done0 && done1) && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.ack0) begin
                if (nack == 0) begin first_t = n; first_p = 0; end
                nack++; ord = {ord[2:0], 1'b0};
                if (!ph0) begin drive(0, 1'b1, 1'b0, 5'd1, 32'd0); ph0 = 1'b1; end
                else begin rd0 = bus.rdata0; drive(0, 1'b0, 1'b0, 5'd1, 32'd0); done0 = 1'b1; end
            end
            if (bus.ack1) begin
                if (nack == 0) begin first_t = n; first_p = 1; end
                nack++; ord = {ord[2:0], 1'b1};
                if (!ph1) begin drive(1, 1'b1, 1'b0, 5'd2, 32'd0); ph1 = 1'b1; end
                else begin rd1 = bus.rdata1; drive(1, 1'b0, 1'b0, 5'd2, 32'd0); done1 = 1'b1; end
            end
        end
        check("first_gnt_port", 32'(first_p), 32'd0);
        check("first_ack_lat",  32'(first_t), 32'd2);
        check("cont_nack",      32'(nack),    32'd4);
        check("cont_order",     32'(ord),     32'b0101);
        check("cont_rdata0",    rd0,          32'd1);
        check("cont_rdata1",    rd1,          32'd2);

        // Single write then read from requester 0.
        run_txn(0, 1'b1, 5'd3, 32'hA5A5_0001, lat, rd);
        check("wr_lat", 32'(lat), 32'd2);
        run_txn(0, 1'b0, 5'd3, 32'd0, lat, rd);
        check("rd_lat",   32'(lat), 32'd3);
        check("rd_data0", rd,       32'hA5A5_0001);

        // Back-to-back reads of addr 10 with req1 held high.
        run_txn(1, 1'b1, 5'd10, 32'd10, lat, rd);
        check("pre_wr_lat", 32'(lat), 32'd2);
        drive(1, 1'b1, 1'b0, 5'd10, 32'd0);
        n = 0; nack = 0; last_t = 0; unstable = 0;
        while (nack < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.ack1) begin
                nack++;
                check("b2b_spacing", 32'(n - last_t), 32'd3);
                check("b2b_rdata1",  bus.rdata1,      32'd10);
                last_t = n;
                if (nack == 4) drive(1, 1'b0, 1'b0, 5'd10, 32'd0);
            end else if (nack == 0) begin
                if (bus.rdata1 !== 32'd2) unstable++;
            end else begin
                if (bus.rdata1 !== 32'd10) unstable++;
            end
        end
        check("b2b_nack",     32'(nack),     32'd4);
        check("b2b_rdata_hold", 32'(unstable), 32'd0);

        // Concurrent write (req0) and read (req1) of addr 31.
        drive(0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF);
        drive(1, 1'b1, 1'b0, 5'd31, 32'd0);
        n = 0; first_p = 9; ack1_t = 0; done0 = 1'b0; done1 = 1'b0; rd1 = '0;
        while (!(done0 && done1) && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.ack0) begin
                if (first_p == 9) first_p = 0;
                drive(0, 1'b0, 1'b0, 5'd31, 32'd0); done0 = 1'b1;
            end
            if (bus.ack1) begin
                if (first_p == 9) first_p = 1;
                rd1 = bus.rdata1; ack1_t = n;
                drive(1, 1'b0, 1'b0, 5'd31, 32'd0); done1 = 1'b1;
            end
        end
        check("raw_first", 32'(first_p), 32'd0);
        check("raw_rdata1", rd1,         32'hFFFF_FFFF);
        check("raw_ack1_t", 32'(ack1_t), 32'd5);

        // Reset landing on the RD_WAIT cycle of a read.
        drive(0, 1'b1, 1'b0, 5'd3, 32'd0);
        @(negedge clk);
        check("mr_acc_cen", 32'(bus.mem_cen), 32'd1);
        @(negedge clk);
        check("mr_rdwait_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 5'd3, 32'd0);
        @(negedge clk);
        check("mr_ack0",   32'(bus.ack0),    32'd0);
        check("mr_busy",   32'(bus.busy),    32'd0);
        check("mr_cen",    32'(bus.mem_cen), 32'd0);
        check("mr_rdata0", bus.rdata0,       32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mr_ack0_after", 32'(bus.ack0), 32'd0);
        run_txn(0, 1'b0, 5'd3, 32'd0, lat, rd);
        check("mr_reread_lat",  32'(lat), 32'd3);
        check("mr_reread_data", rd,       32'hA5A5_0001);

        check("protocol_viol", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the shared 32-word × 32-bit single-port `memory` block. It accepts read/write requests from two independent requesters and grants one transaction at a time. It drives the memory's `cen`/`wen`/`addr`/`din` from registers and returns read data and a one-cycle acknowledge to the winning requester. It sits between the datapath masters and the `memory` instance.

## Interface
- `ADDR_W`, 5: address width; the memory depth is 2^ADDR_W words.
- `DATA_W`, 32: data width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `req0`, `req1`  in  1  request from requester 0 or 1; held high until that requester's `ack`.
- `wr0`, `wr1`  in  1  1 = write, 0 = read; held stable while `req` is high.
- `addr0`, `addr1`  in  ADDR_W  word address; held stable while `req` is high.
- `wdata0`, `wdata1`  in  DATA_W  write data; held stable while `req` is high.
- `ack0`, `ack1`  out  1  one-cycle pulse: the transaction is complete.
- `rdata0`, `rdata1`  out  DATA_W  read data; valid while `ack` is high and held until the next read ack to the same requester.
- `busy`  out  1  high whenever the state is not IDLE.
- `mem_cen`, `mem_wen`  out  1  memory chip enable and write enable, registered.
- `mem_addr`  out  ADDR_W  memory address, registered.
- `mem_din`  out  DATA_W  memory write data, registered.
- `mem_dout`  in  DATA_W  memory read data; valid the cycle after the read access cycle.

## Operation
- **States.** The state machine has three states: IDLE, ACC and RD_WAIT.
- **IDLE.**
  - If any `req` is high, pick a winner. A single requester wins outright. If both request, the one not granted last wins (round-robin).
  - Register the winner's command: `mem_cen`<=1, `mem_wen`<=`wr`, `mem_addr`<=`addr`, `mem_din`<=`wdata`.
  - Record the owner, update the last-grant register, and go to ACC.
- **ACC.** The memory performs the access at the end of this cycle. `mem_cen`<=0 and `mem_wen`<=0.
  - Write: the owner's `ack`<=1, next state IDLE.
  - Read: next state RD_WAIT.
- **RD_WAIT.** The owner's `rdata`<=`mem_dout`, the owner's `ack`<=1, next state IDLE.
- **Ack cycle.** The `ack` pulse is visible in the cycle the FSM is back in IDLE. In that cycle a `req` that is still high counts as a new request. A requester with no further work drops `req` in its ack cycle.
- **Signals outside a transaction.** `mem_addr` and `mem_din` hold their last values; only `mem_cen` qualifies them.
- **Ignored requests.** A request arriving while `busy` is waiting, not lost; it is arbitrated on the next IDLE cycle.
- **Conflicting accesses.** There is no data hazard: transactions are strictly serialized, so a read issued after a write to the same address returns the new data.

## Timing
- **Reset.** While `reset_n`=0 at a rising edge, the following values are set:
  - the state goes to IDLE;
  - all outputs are 0: `ack`, `rdata`, `busy`, `mem_cen`, `mem_wen`, `mem_addr`, `mem_din`;
  - last-grant = 1, so requester 0 wins the first tie.
- **Reset mid-transaction.** The transaction is dropped with no ack, and `mem_cen` is 0 in the cycle after reset. A write whose ACC edge coincided with reset may or may not have been committed.
- **Write latency.** `req` is sampled in IDLE at cycle N; `mem_cen` is high in N+1; `ack` is high in N+2. Sustained write throughput is 1 per 2 cycles.
- **Read latency.** `req` is sampled at cycle N; `mem_cen` is high in N+1; `mem_dout` is valid in N+2; `ack` and `rdata` are visible in N+3. Sustained read throughput is 1 per 3 cycles.
- **Exclusive acks.** `ack0` and `ack1` are never high in the same cycle.
- **Bounded wait.** With both requesters continuously requesting, grants strictly alternate. No requester waits more than one foreign transaction.
- **Strobes.** `mem_cen` is never high for two consecutive cycles.

## Structure
- **Shared package `mem_arb_pkg`.** It holds the state encoding localparams (IDLE=2'd0, ACC=2'd1, RD_WAIT=2'd2) and the default `ADDR_W`/`DATA_W` constants shared with `memory`.
- **Sub-module `rr_arb2`.** A combinational 2-way round-robin picker:
  - inputs: `req0`, `req1`, `last`;
  - outputs: `gnt0`, `gnt1`, one-hot or zero.
- **Top level `mem_arbiter`.** Holds the FSM, the command and owner registers, the last-grant register, and the `rdata` and `ack` registers.

## Test plan
- **Reset.** Hold `reset_n`=0 for 2 cycles with `req0`=`req1`=1 → all outputs 0 and `busy`=0; first grant after release goes to requester 0.
- **Single write then read.** `req0` writes 32'hA5A5_0001 to addr 3; after `ack0`, `req0` reads addr 3 → `ack0` 2 cycles after the write request, `ack0` with `rdata0`=32'hA5A5_0001 3 cycles after the read request.
- **Contention.** Both requesters request continuously; `req0` writes addr 1=1, `req1` writes addr 2=2, then both read → acks alternate 0,1,0,1; `rdata0`=1, `rdata1`=2; `mem_cen` never high for two consecutive cycles.
- **Back-to-back.** `req1` held high across 4 reads of addr 10 (pre-written 10) → `ack1` every 3 cycles with `rdata1`=10; `rdata1` stable between acks.
- **Read-after-write, same address.** `req0` writes addr 31=32'hFFFF_FFFF while `req1` reads addr 31 concurrently → `req0` wins by round-robin; `rdata1`=32'hFFFF_FFFF.
- **Mid-read reset.** Assert `reset_n`=0 in the RD_WAIT cycle → no `ack`, state IDLE, `mem_cen`=0; a subsequent read of the same address completes normally.
